// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit : execute stage of the single-issue core.
//
// Picks operand A and B from the register-file read bus, substitutes the PC
// (branches) and the decoded immediate (load/store/branch), then computes an
// ALU result and a branch-compare flag. Both are registered together with the
// raw register-B value (store data) and the valid flag, giving a fixed
// one-cycle latency with no stall.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset (0 = reset)
//   i_regs      all architectural register values (NUM_REG x DATA_WIDTH)
//   i_select_a  read index for operand A (>= NUM_REG reads as 0)
//   i_select_b  read index for operand B (>= NUM_REG reads as 0)
//   i_pc        current program counter, zero-extended when used as A
//   i_offset    decoded immediate / offset, used as B when i_use_imm
//   i_is_cmp    branch: operand A = PC
//   i_use_imm   operand B = i_offset
//   i_alu_op    ALU operation code (10..15 give 0)
//   i_cmp_op    comparator operation code (6..7 give 0)
//   i_valid     input bundle valid
//   o_alu_data  registered ALU result
//   o_cmp_data  registered compare flag (always on raw reg_a / reg_b)
//   o_reg_b     registered raw register-B value
//   o_valid     registered i_valid
// -----------------------------------------------------------------------------
module exec_unit #(
  parameter int NUM_REG    = 5,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 4,
  localparam int SEL_WIDTH = $clog2(NUM_REG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_regs [NUM_REG],
  input  logic [SEL_WIDTH-1:0]  i_select_a,
  input  logic [SEL_WIDTH-1:0]  i_select_b,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic [DATA_WIDTH-1:0] i_offset,
  input  logic                  i_is_cmp,
  input  logic                  i_use_imm,
  input  logic [3:0]            i_alu_op,
  input  logic [2:0]            i_cmp_op,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_alu_data,
  output logic                  o_cmp_data,
  output logic [DATA_WIDTH-1:0] o_reg_b,
  output logic                  o_valid
);

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  // Read mux that returns 0 for any index past the last register, so an
  // out-of-range select never produces X.
  function automatic logic [DATA_WIDTH-1:0] read_reg(
    input logic [DATA_WIDTH-1:0] regs [NUM_REG],
    input logic [SEL_WIDTH-1:0]  sel
  );
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      val = (sel == SEL_WIDTH'(i)) ? regs[i] : val;
    end
    return val;
  endfunction

  logic [DATA_WIDTH-1:0]  reg_a_s;
  logic [DATA_WIDTH-1:0]  reg_b_s;
  logic [DATA_WIDTH-1:0]  a_s;
  logic [DATA_WIDTH-1:0]  b_s;
  logic [SHAMT_WIDTH-1:0] shamt_s;
  logic [DATA_WIDTH-1:0]  alu_s;
  logic                   cmp_s;

  logic [DATA_WIDTH-1:0]  alu_data_r;
  logic                   cmp_data_r;
  logic [DATA_WIDTH-1:0]  reg_b_r;
  logic                   valid_r;

  // Register read and operand substitution (PC for branches, immediate for
  // address/branch-target arithmetic).
  always_comb begin
    reg_a_s = read_reg(i_regs, i_select_a);
    reg_b_s = read_reg(i_regs, i_select_b);
    a_s     = i_is_cmp  ? DATA_WIDTH'(i_pc) : reg_a_s;
    b_s     = i_use_imm ? i_offset : reg_b_s;
    shamt_s = b_s[SHAMT_WIDTH-1:0];
  end

  // ALU; all results wrap modulo 2^DATA_WIDTH, unused codes give 0.
  always_comb begin
    alu_s = '0;
    case (i_alu_op)
      4'd0:    alu_s = a_s + b_s;
      4'd1:    alu_s = a_s - b_s;
      4'd2:    alu_s = a_s & b_s;
      4'd3:    alu_s = a_s | b_s;
      4'd4:    alu_s = a_s ^ b_s;
      4'd5:    alu_s = a_s << shamt_s;
      4'd6:    alu_s = a_s >> shamt_s;
      4'd7:    alu_s = DATA_WIDTH'($signed(a_s) >>> shamt_s);
      4'd8:    alu_s = DATA_WIDTH'($signed(a_s) < $signed(b_s));
      4'd9:    alu_s = DATA_WIDTH'(a_s < b_s);
      default: alu_s = '0;
    endcase
  end

  // Branch comparator; deliberately on the raw register values, not on the
  // PC/immediate-substituted operands, so the ALU can form the target at once.
  always_comb begin
    cmp_s = 1'b0;
    case (i_cmp_op)
      3'd0:    cmp_s = (reg_a_s == reg_b_s);
      3'd1:    cmp_s = (reg_a_s != reg_b_s);
      3'd2:    cmp_s = ($signed(reg_a_s) <  $signed(reg_b_s));
      3'd3:    cmp_s = ($signed(reg_a_s) >= $signed(reg_b_s));
      3'd4:    cmp_s = (reg_a_s <  reg_b_s);
      3'd5:    cmp_s = (reg_a_s >= reg_b_s);
      default: cmp_s = 1'b0;
    endcase
  end

  // Output pipeline register; captures every cycle, o_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_data_r <= '0;
      cmp_data_r <= 1'b0;
      reg_b_r    <= '0;
      valid_r    <= 1'b0;
    end else begin
      alu_data_r <= alu_s;
      cmp_data_r <= cmp_s;
      reg_b_r    <= reg_b_s;
      valid_r    <= i_valid;
    end
  end

  assign o_alu_data = alu_data_r;
  assign o_cmp_data = cmp_data_r;
  assign o_reg_b    = reg_b_r;
  assign o_valid    = valid_r;

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit : scoreboard bench for exec_unit.
// Stimulus is applied on the falling edge and the expected registered
// response is queued; the monitor pops one entry per rising edge and
// compares all four outputs.
// -----------------------------------------------------------------------------
module tb_exec_unit;

  localparam int NUM_REG    = 5;
  localparam int DATA_WIDTH = 32;
  localparam int PC_WIDTH   = 4;
  localparam int SEL_WIDTH  = 3;

  logic                  clk;
  logic                  rst;
  logic [DATA_WIDTH-1:0] regs [NUM_REG];
  logic [SEL_WIDTH-1:0]  sel_a;
  logic [SEL_WIDTH-1:0]  sel_b;
  logic [PC_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0] offset;
  logic                  is_cmp;
  logic                  use_imm;
  logic [3:0]            alu_op;
  logic [2:0]            cmp_op;
  logic                  valid;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  cmp_data;
  logic [DATA_WIDTH-1:0] reg_b;
  logic                  out_valid;

  typedef struct {
    logic [DATA_WIDTH-1:0] alu;
    logic                  cmp;
    logic [DATA_WIDTH-1:0] rb;
    logic                  vld;
    string                 name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  exec_unit #(
    .NUM_REG(NUM_REG), .DATA_WIDTH(DATA_WIDTH), .PC_WIDTH(PC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .i_regs(regs),
    .i_select_a(sel_a), .i_select_b(sel_b), .i_pc(pc), .i_offset(offset),
    .i_is_cmp(is_cmp), .i_use_imm(use_imm), .i_alu_op(alu_op),
    .i_cmp_op(cmp_op), .i_valid(valid),
    .o_alu_data(alu_data), .o_cmp_data(cmp_data), .o_reg_b(reg_b),
    .o_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one registered response per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (alu_data !== e.alu || cmp_data !== e.cmp || reg_b !== e.rb ||
            out_valid !== e.vld) begin
          n_err++;
          $display("FAIL %s: got alu=%h cmp=%b reg_b=%h valid=%b, expected alu=%h cmp=%b reg_b=%h valid=%b",
                   e.name, alu_data, cmp_data, reg_b, out_valid,
                   e.alu, e.cmp, e.rb, e.vld);
        end
      end
    end
  end

  task automatic apply(
    input logic                  t_rst,
    input logic [2:0]            t_sa,
    input logic [2:0]            t_sb,
    input logic [3:0]            t_pc,
    input logic [31:0]           t_off,
    input logic                  t_is_cmp,
    input logic                  t_use_imm,
    input logic [3:0]            t_alu,
    input logic [2:0]            t_cmp,
    input logic                  t_valid,
    input logic [31:0]           e_alu,
    input logic                  e_cmp,
    input logic [31:0]           e_rb,
    input logic                  e_vld,
    input string                 name
  );
    exp_t e;
    @(negedge clk);
    rst     = t_rst;
    sel_a   = t_sa;
    sel_b   = t_sb;
    pc      = t_pc;
    offset  = t_off;
    is_cmp  = t_is_cmp;
    use_imm = t_use_imm;
    alu_op  = t_alu;
    cmp_op  = t_cmp;
    valid   = t_valid;
    e.alu = e_alu; e.cmp = e_cmp; e.rb = e_rb; e.vld = e_vld; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b0; sel_a = 3'd0; sel_b = 3'd0; pc = 4'd0; offset = 32'd0;
    is_cmp = 1'b0; use_imm = 1'b0; alu_op = 4'd0; cmp_op = 3'd0; valid = 1'b0;
    regs[0] = 32'd1; regs[1] = 32'd2; regs[2] = 32'd3; regs[3] = 32'd0; regs[4] = 32'd0;
    repeat (2) @(posedge clk);

    //     rst   sa    sb    pc    off     cmp   imm   alu    cmpop v     e_alu         e_cmp e_rb          e_v
    apply(1'b0, 3'd1, 3'd0, 4'd0, 32'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 32'd0,        1'b0, 32'd0,        1'b0, "reset");
    apply(1'b1, 3'd1, 3'd0, 4'd0, 32'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 32'd3,        1'b0, 32'd1,        1'b1, "reg_add");
    apply(1'b1, 3'd0, 3'd2, 4'd0, 32'd4,  1'b0, 1'b1, 4'd0,  3'd0, 1'b1, 32'd5,        1'b0, 32'd3,        1'b1, "addr_calc");
    apply(1'b1, 3'd2, 3'd2, 4'd4, 32'd1,  1'b1, 1'b1, 4'd0,  3'd0, 1'b1, 32'd5,        1'b1, 32'd3,        1'b1, "branch_eq_taken");
    apply(1'b1, 3'd2, 3'd0, 4'd4, 32'd1,  1'b1, 1'b1, 4'd0,  3'd0, 1'b1, 32'd5,        1'b0, 32'd1,        1'b1, "branch_eq_not");
    apply(1'b1, 3'd7, 3'd1, 4'd0, 32'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 32'd2,        1'b0, 32'd2,        1'b1, "sel_a_oob");
    apply(1'b1, 3'd0, 3'd1, 4'd0, 32'd0,  1'b0, 1'b0, 4'd12, 3'd7, 1'b1, 32'd0,        1'b0, 32'd2,        1'b1, "illegal_ops");
    apply(1'b1, 3'd0, 3'd0, 4'd0, 32'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 32'd2,        1'b1, 32'd1,        1'b0, "valid_low");

    // Arithmetic-edge register file.
    @(negedge clk);
    regs[0] = 32'd0; regs[1] = 32'd1; regs[2] = 32'hFFFF_FFFF;
    regs[3] = 32'h8000_0000; regs[4] = 32'd2;

    apply(1'b1, 3'd0, 3'd1, 4'd0, 32'd0,  1'b0, 1'b0, 4'd1,  3'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd1,       1'b1, "sub_wrap");
    apply(1'b1, 3'd2, 3'd0, 4'd0, 32'd0,  1'b0, 1'b0, 4'd8,  3'd2, 1'b1, 32'd1,        1'b1, 32'd0,        1'b1, "slt_lt");
    apply(1'b1, 3'd2, 3'd0, 4'd0, 32'd0,  1'b0, 1'b0, 4'd9,  3'd4, 1'b1, 32'd0,        1'b0, 32'd0,        1'b1, "sltu_ltu");
    apply(1'b1, 3'd2, 3'd0, 4'd0, 32'd0,  1'b0, 1'b0, 4'd1,  3'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0,       1'b1, "geu");
    apply(1'b1, 3'd2, 3'd0, 4'd0, 32'd0,  1'b0, 1'b0, 4'd4,  3'd3, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0,       1'b1, "xor_ge");
    apply(1'b1, 3'd3, 3'd0, 4'd0, 32'd31, 1'b0, 1'b1, 4'd7,  3'd1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0,       1'b1, "sra31_ne");
    apply(1'b1, 3'd1, 3'd1, 4'd0, 32'd33, 1'b0, 1'b1, 4'd5,  3'd0, 1'b1, 32'd2,        1'b1, 32'd1,        1'b1, "sll33");
    apply(1'b1, 3'd3, 3'd4, 4'd0, 32'd31, 1'b0, 1'b1, 4'd6,  3'd2, 1'b1, 32'd1,        1'b1, 32'd2,        1'b1, "srl31_lt");
    apply(1'b1, 3'd2, 3'd3, 4'd0, 32'd0,  1'b0, 1'b0, 4'd2,  3'd4, 1'b1, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, "and_ltu");
    apply(1'b1, 3'd1, 3'd4, 4'd0, 32'd0,  1'b0, 1'b0, 4'd3,  3'd3, 1'b1, 32'd3,        1'b0, 32'd2,        1'b1, "or_ge");
    apply(1'b1, 3'd1, 3'd5, 4'd0, 32'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 32'd1,        1'b0, 32'd0,        1'b1, "sel_b_oob");
    apply(1'b0, 3'd2, 3'd3, 4'd9, 32'd7,  1'b1, 1'b1, 4'd0,  3'd1, 1'b1, 32'd0,        1'b0, 32'd0,        1'b0, "reset_inflight");
    apply(1'b1, 3'd4, 3'd4, 4'd0, 32'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 32'd4,        1'b1, 32'd2,        1'b1, "after_reset");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage of the single-issue core.
- Selects operands from the register-file read bus with two read multiplexers, then substitutes PC and immediate operands.
- Computes an ALU result and a branch-compare flag, and registers both for the memory/writeback and PC-update logic.
- Combines the design's mux, ALU and comparator functions behind one registered interface.

Parameters:
- NUM_REG, 5: number of architectural registers on the read bus.
- DATA_WIDTH, 32: register/operand width.
- PC_WIDTH, 4: program-counter width; PC_WIDTH <= DATA_WIDTH.
- SEL_WIDTH is a localparam, not overridable, equal to $clog2(NUM_REG).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low: 0 = reset.
- i_regs  in  NUM_REG x DATA_WIDTH  unpacked array of all register values.
- i_select_a  in  SEL_WIDTH  read index for operand A.
- i_select_b  in  SEL_WIDTH  read index for operand B.
- i_pc  in  PC_WIDTH  current program counter.
- i_offset  in  DATA_WIDTH  decoded immediate/offset.
- i_is_cmp  in  1  branch instruction: A operand = PC.
- i_use_imm  in  1  B operand = i_offset (load/store/branch).
- i_alu_op  in  4  ALU operation code.
- i_cmp_op  in  3  comparator operation code.
- i_valid  in  1  input bundle valid.
- o_alu_data  out  DATA_WIDTH  registered ALU result.
- o_cmp_data  out  1  registered compare result.
- o_reg_b  out  DATA_WIDTH  registered raw register B value (store data).
- o_valid  out  1  registered i_valid.

Behaviour:
- Read muxes (combinational):
  - reg_a = i_regs[i_select_a]; reg_b = i_regs[i_select_b].
  - Any index >= NUM_REG yields 0.
- Operand selection:
  - a = i_is_cmp ? zero-extended i_pc : reg_a.
  - b = i_use_imm ? i_offset : reg_b.
- ALU, computed on a and b, result modulo 2^DATA_WIDTH:
  - 0 ADD: a+b, wraps.
  - 1 SUB: a-b, wraps.
  - 2 AND; 3 OR; 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = b[$clog2(DATA_WIDTH)-1:0].
  - 8 SLT: signed a<b -> 1, else 0, zero-extended.
  - 9 SLTU: unsigned a<b -> 1, else 0.
  - Codes 10-15 produce 0.
- Comparator, always on reg_a and reg_b (never on the PC/immediate-substituted operands):
  - 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU.
  - Codes 6-7 produce 0.
  - o_cmp_data is computed regardless of i_is_cmp; the consumer gates it.
- Pipeline register:
  - All outputs are updated on the rising clk edge; latency is exactly 1 cycle from inputs to outputs.
  - There is no stall or handshake; a new bundle is accepted every cycle.
  - Outputs are captured every cycle irrespective of i_valid; o_valid marks meaningful data.
- Reset:
  - When rst=0 at a rising edge: o_alu_data=0, o_cmp_data=0, o_reg_b=0, o_valid=0.
  - Reset overrides any in-flight bundle.
  - Outputs resume 1 cycle after the first edge with rst=1.
- No internal state besides the output register; no X propagation for out-of-range selects or opcodes.

Test Plan:
1. Reset: hold rst=0 with ADD inputs active; after the edge all outputs = 0. Release rst=1 -> next edge outputs reflect inputs.
2. Register ADD: i_regs={1,2,3,0,0}, sel_a=1, sel_b=0, use_imm=0, ADD -> next cycle o_alu_data=3, o_reg_b=1, o_valid=1.
3. Address calculation: sel_a=0 (value 1), use_imm=1, offset=4, ADD -> o_alu_data=5. Concurrently sel_b=2 -> o_reg_b=3.
4. Branch target and compare: is_cmp=1, pc=4, use_imm=1, offset=1, ADD, cmp EQ, sel_a=sel_b=2 -> o_alu_data=5, o_cmp_data=1. With sel_b=0 instead -> o_cmp_data=0.
5. Arithmetic edges:
   - regs[0]=0, regs[1]=1: SUB a=0, b=1 -> 0xFFFFFFFF.
   - Using regs 0xFFFFFFFF vs 0: SLT -> 1, SLTU -> 0, LT -> 1, LTU -> 0, GEU -> 1.
   - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
   - SLL 1 by 33 -> 2 (shift amount uses low 5 bits).
6. Out-of-range and illegal codes: sel_a=7 -> operand A = 0, so ADD with reg_b=2 -> 2. alu_op=12 -> 0. cmp_op=7 -> 0.
